// File: rtl/dmem_if.sv
// Request/response bus between a load/store pipeline stage and a data memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder: one request in flight, byte/half/word access with
// alignment and range faults, little-endian lanes and sign/zero extension on loads.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic  clk,
  input logic  rst_n,
  dmem_if.slave bus
);

  localparam int unsigned AddrW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          SingleCycle = (LATENCY == 1);
  localparam logic [2:0]  WaitInit    = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, enter_resp, fault;
  logic             cur_we, cur_uns;
  logic [1:0]       cur_size;
  logic [31:0]      cur_addr, cur_wdata;
  logic [AddrW-1:0] word_idx;
  logic [31:0]      old_word, new_word, lane_data, bit_mask, load_val, shifted;
  logic [3:0]       lane_mask;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;

  assign bus.req_ready = (state_q == StIdle) && rst_n;
  assign bus.busy      = (state_q != StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept     = bus.req_valid && bus.req_ready;
  assign enter_resp = (SingleCycle && (state_q == StIdle) && accept) ||
                      ((state_q == StWait) && (cnt_q == 3'd0));

  // With LATENCY=1 the accept edge is also the commit edge, so the live bus fields are used.
  always_comb begin
    cur_we    = we_q;
    cur_uns   = uns_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == StIdle) begin
      cur_we    = bus.req_we;
      cur_uns   = bus.req_unsigned;
      cur_size  = bus.req_size;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end
  end

  always_comb begin
    fault = 1'b0;
    case (cur_size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = cur_addr[0];
      2'b10:   fault = |cur_addr[1:0];
      default: fault = 1'b1;
    endcase
    if ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS) fault = 1'b1;
  end

  assign word_idx = cur_addr[AddrW+1:2];
  assign old_word = mem[word_idx];

  always_comb begin
    lane_mask = 4'b0000;
    lane_data = cur_wdata;
    case (cur_size)
      2'b00: begin
        lane_mask = 4'b0001 << cur_addr[1:0];
        lane_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{cur_wdata[15:0]}};
      end
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
    bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    new_word = (old_word & ~bit_mask) | (lane_data & bit_mask);
  end

  always_comb begin
    shifted   = old_word >> {cur_addr[1:0], 3'b000};
    lane_byte = shifted[7:0];
    lane_half = cur_addr[1] ? old_word[31:16] : old_word[15:0];
    case (cur_size)
      2'b00:   load_val = {{24{~cur_uns & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{~cur_uns & lane_half[15]}}, lane_half};
      default: load_val = old_word;
    endcase
  end

  // Storage is deliberately not reset; a store lands only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && cur_we && !fault) begin
      mem[word_idx] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= enter_resp;
      rsp_err_q   <= enter_resp && fault;
      rsp_rdata_q <= (enter_resp && !cur_we && !fault) ? load_val : '0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (SingleCycle) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 3'd0) state_q <= StResp;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        StResp: begin
          state_q <= StIdle;
          cnt_q   <= 3'd0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder at LATENCY=2, DEPTH_WORDS=1024.
module tb_dmem_responder;
  localparam int unsigned Lat = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY    (Lat)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
  endtask

  task automatic run_req(input vec_t v);
    bit got;
    int lat;
    @(negedge clk);
    drive(v.we, v.addr, v.wdata, v.size, v.uns);
    bus.req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({v.name, " accept"}, 32'(got), 32'd1);
    if (!got) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
    end
    check({v.name, " latency"}, 32'(lat), 32'(Lat));
    check({v.name, " rdata"}, bus.rsp_rdata, v.exp_rdata);
    check({v.name, " err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    @(negedge clk);
    check({v.name, " strobe end"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata[29:0]}, 32'd0);
  endtask

  int n;

  initial begin
    //          we    addr       wdata          size   uns   exp_rdata      err
    vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0, "st w 10"});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, "ld w 10"});
    vecs.push_back('{1'b0, 32'h13,   32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 1'b0, "ld b 13"});
    vecs.push_back('{1'b0, 32'h13,   32'h0,        2'b00, 1'b1, 32'h000000DE, 1'b0, "ld bu 13"});
    vecs.push_back('{1'b0, 32'h12,   32'h0,        2'b01, 1'b0, 32'hFFFFDEAD, 1'b0, "ld h 12"});
    vecs.push_back('{1'b1, 32'h11,   32'h55,       2'b00, 1'b0, 32'h0,        1'b0, "st b 11"});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEAD55EF, 1'b0, "ld w 10 b"});
    vecs.push_back('{1'b1, 32'h12,   32'h12345678, 2'b10, 1'b0, 32'h0,        1'b1, "st w 12 mis"});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEAD55EF, 1'b0, "ld w 10 c"});
    vecs.push_back('{1'b0, 32'h1000, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1, "ld w range"});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        2'b11, 1'b0, 32'h0,        1'b1, "ld size11"});
    vecs.push_back('{1'b1, 32'h14,   32'h0,        2'b10, 1'b0, 32'h0,        1'b0, "st w 14"});
    vecs.push_back('{1'b1, 32'h16,   32'h1234BEEF, 2'b01, 1'b0, 32'h0,        1'b0, "st h 16"});
    vecs.push_back('{1'b0, 32'h14,   32'h0,        2'b10, 1'b0, 32'hBEEF0000, 1'b0, "ld w 14"});
    vecs.push_back('{1'b0, 32'h16,   32'h0,        2'b01, 1'b1, 32'h0000BEEF, 1'b0, "ld hu 16"});
    vecs.push_back('{1'b0, 32'h16,   32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0, "ld h 16"});
    vecs.push_back('{1'b0, 32'h11,   32'h0,        2'b01, 1'b0, 32'h0,        1'b1, "ld h 11 mis"});
    vecs.push_back('{1'b1, 32'h20,   32'h01020304, 2'b10, 1'b0, 32'h0,        1'b0, "st w 20"});
    vecs.push_back('{1'b0, 32'h21,   32'h0,        2'b00, 1'b1, 32'h00000003, 1'b0, "ld bu 21"});
    vecs.push_back('{1'b0, 32'h22,   32'h0,        2'b00, 1'b0, 32'h00000002, 1'b0, "ld b 22"});

    drive(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    bus.req_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1 check("post-rst req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_req(vecs[i]);

    // Reset pulse while a store sits in WAIT: no response, no write.
    @(negedge clk);
    drive(1'b1, 32'h20, 32'hAAAA5555, 2'b10, 1'b0);
    bus.req_valid = 1'b1;
    check("abort ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort rst busy", 32'(bus.busy), 32'd0);
    check("abort rst ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) n++;
    end
    check("abort no rsp", 32'(n), 32'd0);
    run_req('{1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h01020304, 1'b0, "ld w 20 post-abort"});

    // Valid held through BUSY with changed fields: only the first is captured until IDLE.
    @(negedge clk);
    drive(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 drive(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    @(negedge clk);
    check("hold c1 ready", 32'(bus.req_ready), 32'd0);
    check("hold c1 valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("hold c2 ready", 32'(bus.req_ready), 32'd0);
    check("hold c2 valid", 32'(bus.rsp_valid), 32'd1);
    check("hold c2 rdata", bus.rsp_rdata, 32'hDEAD55EF);
    @(negedge clk);
    check("hold c3 ready", 32'(bus.req_ready), 32'd1);
    check("hold c3 valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("hold c4 valid", 32'(bus.rsp_valid), 32'd0);
    check("hold c4 busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("hold c5 valid", 32'(bus.rsp_valid), 32'd1);
    check("hold c5 rdata", bus.rsp_rdata, 32'h01020304);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be:
- DEPTH_WORDS, 1024, number of 32-bit words of backing storage.
- LATENCY, 2, cycles from request accept to response; legal range 1..7.

REQ-002 Ports SHALL be:
- CLK  input  1  single clock; all state changes on rising edge.
- RST  input  1  reset; asynchronous, active-low.
- REQ_VALID  input  1  requester has a request.
- REQ_READY  output  1  responder can accept a request.
- REQ_WE  input  1  1 = store, 0 = load.
- REQ_ADDR  input  32  byte address.
- REQ_WDATA  input  32  store data, right-aligned.
- REQ_SIZE  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- REQ_UNSIGNED  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
- RSP_VALID  output  1  one-cycle response strobe.
- RSP_RDATA  output  32  load result.
- RSP_ERR  output  1  request faulted.
- BUSY  output  1  pipeline stall request.

Function
REQ-003 Handshake: a request SHALL be accepted on a rising edge where REQ_VALID=1 and REQ_READY=1; all request fields SHALL be captured only on that edge.
REQ-004 REQ_READY SHALL be 1 only in state IDLE with RST high.
REQ-005 BUSY SHALL equal (state != IDLE).
REQ-006 The FSM SHALL have states IDLE, WAIT, RESP:
- IDLE->WAIT on accept when LATENCY>1.
- IDLE->RESP on accept when LATENCY=1.
- WAIT->RESP after LATENCY-1 cycles in WAIT, using a 3-bit down-counter.
- RESP->IDLE unconditionally.
REQ-007 RSP_VALID SHALL be 1 for exactly one cycle (the RESP state), LATENCY cycles after the accept edge.
REQ-008 Throughput SHALL be at most one request per LATENCY+1 cycles; the next accept is earliest on the edge ending RESP+1 (first IDLE cycle).
REQ-009 A fault SHALL be flagged when any of the following holds:
- REQ_SIZE=11.
- half access with ADDR[0]=1.
- word access with ADDR[1:0]!=00.
- ADDR[31:2] >= DEPTH_WORDS.
REQ-010 On fault: RSP_ERR=1, RSP_RDATA=0, and no storage modification; the response timing is unchanged.
REQ-011 Stores SHALL commit on the edge entering RESP, using little-endian byte lanes:
- byte: lane ADDR[1:0] gets WDATA[7:0].
- half: lanes {ADDR[1],0}+1..{ADDR[1],0} get WDATA[15:0].
- word: all lanes.
- Unselected lanes SHALL be unchanged.
REQ-012 Loads SHALL read the addressed word, select the byte or half by ADDR[1:0], extend per REQ_UNSIGNED to 32 bits, and present the result on RSP_RDATA during RESP.
REQ-013 On a store response RSP_RDATA SHALL be 0. RSP_RDATA and RSP_ERR SHALL be 0 whenever RSP_VALID=0.
REQ-014 REQ_VALID asserted while BUSY SHALL be ignored (no capture); the requester holds its request until accepted.
REQ-015 A load following a store to the same address SHALL return the stored data.

Reset
REQ-016 While RST=0: state=IDLE, counter=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, BUSY=0, REQ_READY=0.
REQ-017 Reset asserted mid-operation SHALL abandon the in-flight request with no response. An uncommitted store SHALL not modify storage.
REQ-018 Storage contents SHALL NOT be cleared by reset.
REQ-019 The first accept after release SHALL be possible on the first rising edge with RST=1.

Verification (LATENCY=2, DEPTH_WORDS=1024)
REQ-020 Reset: RST=0 -> RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, BUSY=0, REQ_READY=0; after release -> REQ_READY=1.
REQ-021 Word store 0xDEADBEEF @0x10, then word load @0x10 -> RSP_RDATA=0xDEADBEEF, RSP_ERR=0, RSP_VALID exactly 2 cycles after each accept and high 1 cycle.
REQ-022 Extension, after REQ-021:
- signed byte load @0x13 -> 0xFFFFFFDE.
- unsigned byte load @0x13 -> 0x000000DE.
- signed half load @0x12 -> 0xFFFFDEAD.
REQ-023 Byte store 0x55 @0x11, then word load @0x10 -> 0xDEAD55EF.
REQ-024 Faults:
- word store 0x12345678 @0x12 -> RSP_ERR=1, RSP_RDATA=0; word load @0x10 still returns 0xDEAD55EF.
- word load @0x1000 -> RSP_ERR=1.
- REQ_SIZE=11 -> RSP_ERR=1.
REQ-025 Word store 0xAAAA5555 @0x20 with RST pulsed low during WAIT -> no RSP_VALID; a later load @0x20 returns its prior value. REQ_VALID held high while BUSY -> no second capture, REQ_READY=0 until IDLE.
